sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares the single SRAM_Controller port between up to NUM_REQ requesters, e.g. 0 = VGA fetch, 1 = colourspace-converter Y/U/V reads, 2 = RGB writeback.
- Arbitrates one access per cycle, using round-robin with an optional burst lock.
- Drives the controller's registered address, write-data and write-enable.
- Routes returning read data back to the originating requester after the fixed SRAM read latency.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, 18, SRAM address width.
- DATA_W, 16, SRAM data width.
- READ_LATENCY, 2, cycles from the SRAM_address-valid cycle to the matching SRAM_read_data-valid cycle.

Ports:
- Clock_50  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester access request; held until accepted.
- req_we_n  in  NUM_REQ  per-requester access type: 0 = write, 1 = read.
- req_lock  in  NUM_REQ  keep the grant on the next cycle (burst).
- req_address  in  NUM_REQ*ADDR_W  packed addresses; requester k occupies slice k.
- req_write_data  in  NUM_REQ*DATA_W  packed write data.
- grant  out  NUM_REQ  combinational one-hot; the access is accepted at the edge where req[k]&grant[k].
- rdata_valid  out  NUM_REQ  registered one-hot pulse; read data for requester k is valid.
- rdata  out  DATA_W  registered copy of SRAM_read_data, shared by all requesters.
- SRAM_address  out  ADDR_W  to SRAM_Controller.
- SRAM_write_data  out  DATA_W  to SRAM_Controller.
- SRAM_we_n  out  1  to SRAM_Controller.
- SRAM_read_data  in  DATA_W  from SRAM_Controller.

Behaviour:
- Reset values: SRAM_address=0, SRAM_write_data=0, SRAM_we_n=1, rdata=0, rdata_valid=0, rr_ptr=0, lock_owner invalid, in-flight tag pipeline cleared. grant=0 while Reset is high.
- Arbitration (combinational, every cycle):
  - If lock_owner is valid and req[lock_owner]=1, grant that requester.
  - Otherwise grant the first k with req[k]=1, searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - If no req is high, grant=0.
- On an accept edge (requester k):
  - SRAM_address <= req_address[k]; SRAM_we_n <= req_we_n[k]; SRAM_write_data <= req_write_data[k].
  - rr_ptr <= (k+1) mod NUM_REQ.
  - lock_owner <= k if req_lock[k]=1, else invalid.
- On a no-accept cycle:
  - SRAM_we_n <= 1; SRAM_address and SRAM_write_data hold their values.
  - lock_owner is cleared.
- Read tracking:
  - A read accept pushes {valid, k} into a tag shift register of depth READ_LATENCY+1.
  - When the tag exits: rdata <= SRAM_read_data and rdata_valid[k] <= 1 for one cycle.
  - Net effect: rdata_valid[k] is high READ_LATENCY+1 cycles after the SRAM_address-valid cycle. Constant latency, fully pipelined, one access per cycle.
- Writes push an invalid tag and never produce rdata_valid.
- A locked requester that drops req loses the lock immediately; arbitration falls back to round-robin in the same cycle.
- Reset mid-operation discards all in-flight tags; no rdata_valid is emitted for reads issued before reset.
- A requester changing its address while req is high and not yet granted is legal; the arbiter samples only at acceptance.

Optional Feature:
- Macro SRAM_ARB_PRIORITY0_EN.
- Defined: requester 0 has strict priority over round-robin. An active lock held by another requester is still honoured; requester 0 wins the first cycle that requester is unlocked. rr_ptr is updated only by accepts from requesters other than 0.
- Undefined: pure round-robin as above.

Decomposition:
- Shared package sram_arb_pkg holds:
  - SRAM map constants: Y_OFFSET=0, U_OFFSET=38400, V_OFFSET=57600, RGB_OFFSET=146944.
  - typedef for the read tag {logic valid; logic [2:0] id;}.
  - typedef for the address type.
- One sub-module: rr_priority_select, which takes request vector and pointer and returns a one-hot select; it is reused for the priority path.

Test Plan:
- Reset: hold Reset 3 cycles with all req=1 -> grant=0, SRAM_we_n=1, SRAM_address=0, rdata_valid=0; after release, first grant is requester 0.
- Single read: req[1]=1, address 146944 -> grant[1] same cycle; SRAM_address=146944 with SRAM_we_n=1 next cycle; SRAM model returns 0xABCD; rdata_valid=3'b010 and rdata=0xABCD exactly READ_LATENCY+1 cycles after the address cycle.
- Contention: req=3'b111 held, no lock -> accept order 0,1,2,0,1,2. With SRAM_ARB_PRIORITY0_EN defined -> 0,0,0….
- Lock: req[1] with lock for 4 beats while req[0] and req[2] are pending -> accepts 1,1,1,1, then 2, then 0.
- Write: req[2], we_n=0, address 38400, data 0x1234 -> SRAM_we_n=0 for exactly one cycle with those values; no rdata_valid pulse.
- Reset mid-flight: read accepted, Reset asserted the next cycle for 1 cycle -> no rdata_valid ever; the next accept after reset starts from rr_ptr=0.

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter: SRAM memory map, the read-tag
// record carried through the read-latency pipeline and the address type.
package sram_arb_pkg;

    // SRAM memory map (word addresses)
    localparam int unsigned Y_OFFSET   = 0;
    localparam int unsigned U_OFFSET   = 38400;
    localparam int unsigned V_OFFSET   = 57600;
    localparam int unsigned RGB_OFFSET = 146944;

    localparam int SRAM_ADDR_W = 18;

    typedef logic [SRAM_ADDR_W-1:0] sram_addr_t;

    // One entry of the in-flight read pipeline; id is wide enough for 8 requesters
    typedef struct packed {
        logic       valid;
        logic [2:0] id;
    } rd_tag_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester/SRAM bus of the SRAM port arbiter.
// slave  = arbiter side, master = requesters plus SRAM controller side.
interface sram_port_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 16
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we_n;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ*ADDR_W-1:0] req_address;
    logic [NUM_REQ*DATA_W-1:0] req_write_data;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        rdata_valid;
    logic [DATA_W-1:0]         rdata;
    logic [ADDR_W-1:0]         SRAM_address;
    logic [DATA_W-1:0]         SRAM_write_data;
    logic                      SRAM_we_n;
    logic [DATA_W-1:0]         SRAM_read_data;

    modport slave (
        input  req, req_we_n, req_lock, req_address, req_write_data, SRAM_read_data,
        output grant, rdata_valid, rdata, SRAM_address, SRAM_write_data, SRAM_we_n
    );

    modport master (
        output req, req_we_n, req_lock, req_address, req_write_data, SRAM_read_data,
        input  grant, rdata_valid, rdata, SRAM_address, SRAM_write_data, SRAM_we_n
    );
endinterface

// File: rtl/sram_port_arbiter_rr_priority_select.sv
// Rotating first-one select: returns a one-hot pick of the first set request
// found searching from position ptr upwards, wrapping modulo NUM_REQ.
// With ptr tied to 0 it degenerates to a fixed lowest-index priority select.
module rr_priority_select #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         ptr,
    output logic [NUM_REQ-1:0] sel
);
    logic [2*NUM_REQ-1:0] rot;
    logic [2*NUM_REQ-1:0] unrot;
    logic [NUM_REQ-1:0]   first;
    logic                 found;

    // Rotate so ptr sits at bit 0, take the first one, rotate the pick back
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        first = '0;
        found = 1'b0;
        rot   = {req, req} >> ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && rot[i]) begin
                first[i] = 1'b1;
                found    = 1'b1;
            end
        end
        unrot = {first, first} << ptr;
        sel   = unrot[2*NUM_REQ-1:NUM_REQ];
    end
endmodule

// File: rtl/sram_port_arbiter.sv
// SRAM port arbiter: shares one SRAM_Controller port between NUM_REQ requesters,
// one access per cycle, round-robin with burst lock, registered SRAM outputs and
// read data routed back by a tag pipeline matching the fixed read latency.
// Optional macro SRAM_ARB_PRIORITY0_EN gives requester 0 strict priority.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int ADDR_W       = 18,
    parameter int DATA_W       = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic                       Clock_50,
    input  logic                       Reset,
    sram_port_arbiter_if.slave         bus
);
    localparam int TAG_DEPTH = READ_LATENCY + 1;

    logic [ADDR_W-1:0]  sram_address_q, sram_address_d;
    logic [DATA_W-1:0]  sram_write_data_q, sram_write_data_d;
    logic               sram_we_n_q, sram_we_n_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [NUM_REQ-1:0] rdata_valid_q, rdata_valid_d;
    logic [2:0]         rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] lock_q, lock_d;     // one-hot owner, all-zero = no lock
    rd_tag_t            tag_q [TAG_DEPTH];
    rd_tag_t            tag_d [TAG_DEPTH];

    logic [NUM_REQ-1:0] rr_sel, arb_sel, grant;
    logic               accept;

    rr_priority_select #(.NUM_REQ(NUM_REQ)) u_rr_sel (
        .req (bus.req),
        .ptr (rr_ptr_q),
        .sel (rr_sel)
    );

`ifdef SRAM_ARB_PRIORITY0_EN
    logic [NUM_REQ-1:0] prio_sel;

    rr_priority_select #(.NUM_REQ(NUM_REQ)) u_prio_sel (
        .req (bus.req),
        .ptr (3'd0),
        .sel (prio_sel)
    );

    // Requester 0 pre-empts the round-robin pick whenever it is requesting
    always_comb begin
        arb_sel = prio_sel[0] ? prio_sel : rr_sel;
    end
`else
    // Pure round-robin pick
    always_comb begin
        arb_sel = rr_sel;
    end
`endif

    // Grant: active lock owner first, otherwise the arbitration pick; nothing in reset
    always_comb begin
        grant = '0;
        if (!Reset) begin
            if (|(lock_q & bus.req)) begin
                grant = lock_q;
            end else begin
                grant = arb_sel;
            end
        end
    end

    // Next state: capture the accepted access, advance pointer/lock, shift read tags
    always_comb begin
        accept            = |(bus.req & grant);
        sram_address_d    = sram_address_q;
        sram_write_data_d = sram_write_data_q;
        sram_we_n_d       = 1'b1;
        rr_ptr_d          = rr_ptr_q;
        lock_d            = '0;
        tag_d[0]          = '0;
        for (int i = 1; i < TAG_DEPTH; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        for (int k = 0; k < NUM_REQ; k++) begin
            if (accept && grant[k]) begin
                sram_address_d    = bus.req_address[k*ADDR_W +: ADDR_W];
                sram_write_data_d = bus.req_write_data[k*DATA_W +: DATA_W];
                sram_we_n_d       = bus.req_we_n[k];
                lock_d[k]         = bus.req_lock[k];
                tag_d[0].valid    = bus.req_we_n[k];
                tag_d[0].id       = 3'(k);
`ifdef SRAM_ARB_PRIORITY0_EN
                if (k != 0) begin
                    rr_ptr_d = (k + 1 == NUM_REQ) ? 3'd0 : 3'(k + 1);
                end
`else
                rr_ptr_d = (k + 1 == NUM_REQ) ? 3'd0 : 3'(k + 1);
`endif
            end
        end

        rdata_d       = rdata_q;
        rdata_valid_d = '0;
        if (tag_q[TAG_DEPTH-1].valid) begin
            rdata_d = bus.SRAM_read_data;
            for (int k = 0; k < NUM_REQ; k++) begin
                rdata_valid_d[k] = (tag_q[TAG_DEPTH-1].id == 3'(k));
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge Clock_50) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (Reset) begin
            sram_address_q    <= '0;
            sram_write_data_q <= '0;
            sram_we_n_q       <= 1'b1;
            rdata_q           <= '0;
            rdata_valid_q     <= '0;
            rr_ptr_q          <= '0;
            lock_q            <= '0;
            // NOTE: the tag pipeline is a few flops, not a RAM, and must be cleared so reads issued before reset never return.
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            sram_address_q    <= sram_address_d;
            sram_write_data_q <= sram_write_data_d;
            sram_we_n_q       <= sram_we_n_d;
            rdata_q           <= rdata_d;
            rdata_valid_q     <= rdata_valid_d;
            rr_ptr_q          <= rr_ptr_d;
            lock_q            <= lock_d;
            tag_q             <= tag_d;
        end
    end

    assign bus.grant           = grant;
    assign bus.rdata_valid     = rdata_valid_q;
    assign bus.rdata           = rdata_q;
    assign bus.SRAM_address    = sram_address_q;
    assign bus.SRAM_write_data = sram_write_data_q;
    assign bus.SRAM_we_n       = sram_we_n_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a small SRAM model of fixed read
// latency. Expectations follow the default (round-robin) build; the contention
// order switches when SRAM_ARB_PRIORITY0_EN is defined.
module tb_sram_port_arbiter;
    import sram_arb_pkg::*;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 18;
    localparam int DATA_W  = 16;
    localparam int RL      = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sram_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_port_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(RL)
    ) dut (
        .Clock_50 (clk),
        .Reset    (rst),
        .bus      (bus)
    );

    // SRAM model: data for the address of cycle A appears on read data in cycle A+RL
    logic [DATA_W-1:0] sram_p1 = '0;
    logic [DATA_W-1:0] sram_p2 = '0;

    function automatic logic [DATA_W-1:0] sram_word(input logic [ADDR_W-1:0] a);
        if (a == sram_addr_t'(RGB_OFFSET)) return 16'hABCD;
        return a[15:0] ^ 16'h5A5A;
    endfunction

    always @(posedge clk) begin
        sram_p1 <= sram_word(bus.SRAM_address);
        sram_p2 <= sram_p1;
    end
    assign bus.SRAM_read_data = sram_p2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int k, input logic we_n, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
        bus.req_we_n[k]                     = we_n;
        bus.req_address[k*ADDR_W +: ADDR_W] = a;
        bus.req_write_data[k*DATA_W +: DATA_W] = d;
    endtask

    int          exp_id [7];
    logic [ADDR_W-1:0] base [NUM_REQ];

    initial begin
        bus.req            = '1;
        bus.req_we_n       = '1;
        bus.req_lock       = '0;
        bus.req_address    = '0;
        bus.req_write_data = '0;

        // Reset held 3 cycles with every requester asking
        repeat (3) begin
            tick();
            chk("reset_grant", 32'(bus.grant), 32'h0);
            chk("reset_we_n", 32'(bus.SRAM_we_n), 32'h1);
            chk("reset_addr", 32'(bus.SRAM_address), 32'h0);
            chk("reset_rvalid", 32'(bus.rdata_valid), 32'h0);
        end
        rst = 1'b0;
        #1;
        chk("first_grant", 32'(bus.grant), 32'h1);
        bus.req = '0;
        tick();

        // Single read from requester 1
        set_slot(1, 1'b1, sram_addr_t'(RGB_OFFSET), 16'h0);
        bus.req = 3'b010;
        #1;
        chk("rd_grant", 32'(bus.grant), 32'h2);
        tick();
        bus.req = '0;
        chk("rd_addr", 32'(bus.SRAM_address), RGB_OFFSET);
        chk("rd_we_n", 32'(bus.SRAM_we_n), 32'h1);
        chk("rd_rvalid_a0", 32'(bus.rdata_valid), 32'h0);
        tick();
        chk("rd_rvalid_a1", 32'(bus.rdata_valid), 32'h0);
        tick();
        chk("rd_rvalid_a2", 32'(bus.rdata_valid), 32'h0);
        tick();
        chk("rd_rvalid_a3", 32'(bus.rdata_valid), 32'h2);
        chk("rd_rdata", 32'(bus.rdata), 32'hABCD);
        tick();
        chk("rd_rvalid_pulse", 32'(bus.rdata_valid), 32'h0);

        // Write from requester 2 (pointer now at 2)
        set_slot(2, 1'b0, sram_addr_t'(U_OFFSET), 16'h1234);
        bus.req = 3'b100;
        #1;
        chk("wr_grant", 32'(bus.grant), 32'h4);
        tick();
        bus.req      = '0;
        bus.req_we_n = '1;
        chk("wr_we_n", 32'(bus.SRAM_we_n), 32'h0);
        chk("wr_addr", 32'(bus.SRAM_address), U_OFFSET);
        chk("wr_data", 32'(bus.SRAM_write_data), 32'h1234);
        tick();
        chk("wr_we_n_release", 32'(bus.SRAM_we_n), 32'h1);
        chk("wr_addr_hold", 32'(bus.SRAM_address), U_OFFSET);
        chk("wr_data_hold", 32'(bus.SRAM_write_data), 32'h1234);
        repeat (3) begin
            tick();
            chk("wr_no_rvalid", 32'(bus.rdata_valid), 32'h0);
        end

        // Contention: all three reading, no lock (pointer back at 0)
        base[0] = sram_addr_t'(Y_OFFSET + 5);
        base[1] = sram_addr_t'(V_OFFSET + 7);
        base[2] = sram_addr_t'(RGB_OFFSET + 9);
        for (int k = 0; k < NUM_REQ; k++) set_slot(k, 1'b1, base[k], 16'h0);
`ifdef SRAM_ARB_PRIORITY0_EN
        exp_id = '{0, 0, 0, 0, 0, 0, 0};
`else
        exp_id = '{0, 1, 2, 0, 1, 2, 0};
`endif
        bus.req = 3'b111;
        for (int i = 0; i < 7; i++) begin
            #1;
            chk("cont_grant", 32'(bus.grant), 32'(1) << exp_id[i]);
            tick();
            chk("cont_addr", 32'(bus.SRAM_address), 32'(base[exp_id[i]]));
        end
        bus.req = '0;
        repeat (4) tick();

`ifndef SRAM_ARB_PRIORITY0_EN
        // Burst lock: requester 1 holds 4 beats while 0 and 2 wait (pointer at 1)
        bus.req      = 3'b111;
        bus.req_lock = 3'b010;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.req_lock = '0;
            #1;
            chk("lock_beat", 32'(bus.grant), 32'h2);
            tick();
        end
        bus.req = 3'b101;
        #1;
        chk("lock_after_2", 32'(bus.grant), 32'h4);
        tick();
        #1;
        chk("lock_after_0", 32'(bus.grant), 32'h1);
        tick();
        bus.req = '0;
        repeat (4) tick();
`endif

        // Reset one cycle after a read is accepted
        set_slot(1, 1'b1, sram_addr_t'(V_OFFSET), 16'h0);
        bus.req = 3'b010;
        #1;
        chk("mid_grant", 32'(bus.grant), 32'h2);
        tick();
        rst     = 1'b1;
        bus.req = 3'b111;
        #1;
        chk("grant_in_reset", 32'(bus.grant), 32'h0);
        tick();
        rst     = 1'b0;
        bus.req = '0;
        chk("mid_addr_cleared", 32'(bus.SRAM_address), 32'h0);
        repeat (5) begin
            chk("mid_no_rvalid", 32'(bus.rdata_valid), 32'h0);
            tick();
        end
        bus.req = 3'b111;
        #1;
        chk("rr_after_reset", 32'(bus.grant), 32'h1);
        bus.req = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
